// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  // One second of LED hold time at 50 MHz.
  localparam int unsigned STRETCH_CYC_DEFAULT = 50_000_000;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pattern_detector_led_stretch.sv
// Retriggerable pulse stretcher: led stays high for STRETCH_CYC cycles after the latest trig.
module led_stretch
  import pattern_detector_pkg::*;
#(
  parameter int unsigned STRETCH_CYC = STRETCH_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic led
);

  localparam int unsigned CW = cnt_width(STRETCH_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;

  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (trig) begin
      led_d = 1'b1;
      cnt_d = CW'(STRETCH_CYC - 1);
    end else if (led_q) begin
      // The cycle in which the count sits at zero is the last lit cycle.
      if (cnt_q == '0) led_d = 1'b0;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with loadable pattern, overlap mode and stretched LED output.
// Define PATTERN_DETECTOR_HIT_COUNT_EN to add the saturating hit_count output.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int unsigned       PAT_W       = 4,
  parameter logic [PAT_W-1:0]  PAT_RESET   = PAT_W'(4'b1011),
  parameter int unsigned       STRETCH_CYC = STRETCH_CYC_DEFAULT,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             detect,
  output logic             led_on
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  localparam int unsigned FW = cnt_width(PAT_W);

  // The oldest window bit is never needed after the compare, so only the
  // newest PAT_W-1 bits are stored; {hist_q, din} is the full window.
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             detect_q, detect_d;
  logic [PAT_W-1:0] window;
  logic             match;
  mode_e            mode;

  assign mode = mode_e'(overlap);

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    detect_d = 1'b0;
    window   = {hist_q, din};
    match    = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = window[PAT_W-2:0];
      match  = (fill_q >= FW'(PAT_W - 1)) && (window == pat_q);
      if (match && mode == MODE_NONOVERLAP) fill_d = '0;
      else if (fill_q != FW'(PAT_W))        fill_d = fill_q + FW'(1);
      detect_d = match;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= PAT_RESET;
      hist_q   <= '0;
      fill_q   <= '0;
      detect_q <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      detect_q <= detect_d;
    end
  end

  assign detect = detect_q;

  led_stretch #(
    .STRETCH_CYC(STRETCH_CYC)
  ) u_led_stretch (
    .clk  (clk),
    .rst_n(rst_n),
    .trig (detect_q),
    .led  (led_on)
  );

`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_q, hit_d;

  // Counted on the same edge that raises detect, so both move together.
  always_comb begin
    hit_d = hit_q;
    if (detect_d && hit_q != '1) hit_d = hit_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: directed vector table, hand sequences, random vs. queue model.
// Exercises hit_count when PATTERN_DETECTOR_HIT_COUNT_EN is defined.
module tb_pattern_detector;

  localparam int PAT_W = 4;
  localparam int S     = 8;
  localparam int CNT_W = 2;
  localparam int HIT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             overlap = 1'b0;
  logic             detect;
  logic             led_on;
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_count;
`endif

  always #5 clk = ~clk;

  pattern_detector #(
    .PAT_W      (PAT_W),
    .PAT_RESET  (4'b1011),
    .STRETCH_CYC(S),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .din      (din),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .overlap  (overlap),
    .detect   (detect),
    .led_on   (led_on)
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
    ,
    .hit_count(hit_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the list of valid bits received since the last clear.
  int               win[$];
  logic [PAT_W-1:0] m_pat = 4'b1011;
  int               last_det = -1;
  int               cyc = 0;
  int               m_hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic ld,
                      input logic [PAT_W-1:0] pin, input logic ov, output logic exp_det);
    logic exp_led;
    din_valid = v;
    din       = d;
    pat_load  = ld;
    pat_in    = pin;
    overlap   = ov;
    exp_det   = 1'b0;
    if (ld) begin
      m_pat = pin;
      win.delete();
    end else if (v) begin
      win.push_back(int'(d));
      if (win.size() > PAT_W) void'(win.pop_front());
      if (win.size() == PAT_W) begin
        exp_det = 1'b1;
        for (int i = 0; i < PAT_W; i++)
          if (win[i] != int'(m_pat[PAT_W-1-i])) exp_det = 1'b0;
      end
      if (exp_det && !ov) win.delete();
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_led = (last_det >= 0) && (cyc - last_det >= 1) && (cyc - last_det <= S);
    if (exp_det) begin
      last_det = cyc;
      if (m_hits < HIT_MAX) m_hits++;
    end
    check("detect", 32'(detect), 32'(exp_det));
    check("led_on", 32'(led_on), 32'(exp_led));
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
    check("hit_count", 32'(hit_count), 32'(m_hits));
`endif
  endtask

  // Called at a falling edge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    din_valid = 1'b0;
    pat_load  = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_detect", 32'(detect), 32'd0);
    check("rst_led_on", 32'(led_on), 32'd0);
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
    check("rst_hit_count", 32'(hit_count), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    win.delete();
    m_pat    = 4'b1011;
    last_det = -1;
    m_hits   = 0;
  endtask

  typedef struct {
    bit               rst;
    bit               v;
    bit               d;
    bit               ld;
    logic [PAT_W-1:0] pin;
    bit               ov;
    bit               exp_det;
    bit               chk_hits;
    int               exp_hits;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit v, bit d, bit ld, logic [PAT_W-1:0] pin,
                              bit ov, bit exp_det, bit chk_hits = 0, int exp_hits = 0);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.ld = ld; r.pin = pin; r.ov = ov;
    r.exp_det = exp_det; r.chk_hits = chk_hits; r.exp_hits = exp_hits;
    tbl.push_back(r);
  endfunction

  function automatic void bit_row(bit d, bit ov, bit exp_det, bit chk_hits = 0, int exp_hits = 0);
    add(0, 1, d, 0, 4'b0000, ov, exp_det, chk_hits, exp_hits);
  endfunction

  function automatic void idle_rows(int n, bit d, bit ov);
    for (int i = 0; i < n; i++) add(0, 0, d, 0, 4'b0000, ov, 0);
  endfunction

  initial begin
    logic md;
    int   run;
    bit   ended;

    // Overlapping mode: 1,0,1,1,0,1,1 hits after bits 4 and 7.
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    bit_row(1, 1, 0); bit_row(0, 1, 0); bit_row(1, 1, 0); bit_row(1, 1, 1);
    bit_row(0, 1, 0); bit_row(1, 1, 0); bit_row(1, 1, 1, 1, 2);
    // Non-overlapping mode: same stream hits once.
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 1);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 0, 1, 1);
    // Load 0110 with a same-cycle valid bit that must be ignored; old pattern dead.
    add(0, 1, 1, 1, 4'b0110, 0, 0);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 1);
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 0, 1, 2);
    // Idle gaps; idle din would complete the match if it were sampled.
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    bit_row(1, 1, 0); idle_rows(3, 0, 1);
    bit_row(0, 1, 0); idle_rows(3, 1, 1);
    bit_row(1, 1, 0); idle_rows(3, 1, 1);
    bit_row(1, 1, 1); idle_rows(3, 1, 1);
    // Reset after 1,0,1 forgets the partial window.
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    bit_row(1, 1, 0); bit_row(0, 1, 0); bit_row(1, 1, 0);
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    bit_row(1, 1, 0); bit_row(0, 1, 0); bit_row(1, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        step(tbl[i].v, tbl[i].d, tbl[i].ld, tbl[i].pin, tbl[i].ov, md);
        check("tbl_detect", 32'(detect), 32'(tbl[i].exp_det));
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
        if (tbl[i].chk_hits) check("tbl_hit_count", 32'(hit_count), 32'(tbl[i].exp_hits));
`endif
      end
    end

    // Retrigger: detects 5 cycles apart keep led_on high for 5 + S cycles.
    do_reset();
    step(1, 1, 0, '0, 1, md); step(1, 0, 0, '0, 1, md);
    step(1, 1, 0, '0, 1, md); step(1, 1, 0, '0, 1, md);
    run = 0;
    ended = 0;
    for (int i = 0; i < 25; i++) begin
      case (i)
        2: step(1, 0, 0, '0, 1, md);
        3: step(1, 1, 0, '0, 1, md);
        4: step(1, 1, 0, '0, 1, md);
        default: step(0, 0, 0, '0, 1, md);
      endcase
      if (!ended) begin
        if (led_on) run++;
        else ended = 1;
      end
    end
    check("led_run_length", 32'(run), 32'(5 + S));

    // Reset in the middle of a stretch drops the LED at once.
    step(1, 0, 0, '0, 1, md); step(1, 1, 0, '0, 1, md);
    step(1, 1, 0, '0, 1, md);
    step(0, 0, 0, '0, 1, md);
    do_reset();
    step(0, 0, 0, '0, 1, md);
    step(1, 1, 0, '0, 1, md);

    // Five overlapping hits saturate a 2-bit counter.
    do_reset();
    step(1, 1, 0, '0, 1, md); step(1, 0, 0, '0, 1, md);
    step(1, 1, 0, '0, 1, md); step(1, 1, 0, '0, 1, md);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, '0, 1, md); step(1, 1, 0, '0, 1, md); step(1, 1, 0, '0, 1, md);
    end
`ifdef PATTERN_DETECTOR_HIT_COUNT_EN
    check("hit_count_saturated", 32'(hit_count), 32'(HIT_MAX));
`endif

    // Random traffic against the model.
    begin
      logic ov_r;
      ov_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(399) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(49) == 0) ov_r = ~ov_r;
          step(($urandom_range(9) < 7), 1'($urandom), ($urandom_range(39) == 0),
               PAT_W'($urandom), ov_r, md);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
